// File: rtl/mil_spi_frame_router.sv
// mil_spi_frame_router
//
// Service-protocol frame router on the SPI side of the MIL-STD-1553 <-> SPI
// converter. It parses the incoming 16-bit word stream into frames of the form
//   ADDR, SIZE, <size payload words>, CSUM, NUM
// and forwards the payload words to one of CHANNELS channels. A channel answers
// the block address BASE_ADDR + k. At frame end the checksum is verified and a
// commit (good) or abort (bad) pulse goes to the addressed channel. If a frame
// is left hanging, an inactivity timeout returns the parser to IDLE and aborts
// the channel.
//
// Ports
//   clk, nRst    system clock, asynchronous active-low reset
//   in_data      word from the SPI receiver
//   in_valid     one-cycle strobe qualifying in_data (always consumed)
//   out_data     payload word, registered
//   out_valid    one-hot per-channel strobe for out_data
//   out_cmd      command byte of the current frame, held until the next SIZE
//   out_commit   one-hot pulse, frame accepted
//   out_abort    one-hot pulse, discard words since the last commit
//   frame_done   pulse at frame end (NUM word or timeout)
//   frame_err    0 ok, 1 checksum, 2 timeout, 3 unknown address
//   frame_ch     channel index of the finished frame
//   frame_num    trailing word-number field (0 on timeout)
//   busy         parser is inside a frame

module mil_spi_frame_router #(
  parameter int         CHANNELS  = 2,
  parameter logic [7:0] BASE_ADDR = 8'hAB,
  parameter int         TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic [15:0]         in_data,
  input  logic                in_valid,
  output logic [15:0]         out_data,
  output logic [CHANNELS-1:0] out_valid,
  output logic [7:0]          out_cmd,
  output logic [CHANNELS-1:0] out_commit,
  output logic [CHANNELS-1:0] out_abort,
  output logic                frame_done,
  output logic [1:0]          frame_err,
  output logic [2:0]          frame_ch,
  output logic [15:0]         frame_num,
  output logic                busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIZE,
    ST_DATA,
    ST_CSUM,
    ST_NUM
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ADDR    = 2'd3;

  state_t state_q, state_d;

  logic [15:0]         sum_q, sum_d;
  logic [7:0]          remain_q, remain_d;
  logic                matched_q, matched_d;
  logic [2:0]          ch_q, ch_d;
  logic                csum_ok_q, csum_ok_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;

  logic [15:0]         out_data_q, out_data_d;
  logic [CHANNELS-1:0] out_valid_q, out_valid_d;
  logic [7:0]          out_cmd_q, out_cmd_d;
  logic [CHANNELS-1:0] out_commit_q, out_commit_d;
  logic [CHANNELS-1:0] out_abort_q, out_abort_d;
  logic                frame_done_q, frame_done_d;
  logic [1:0]          frame_err_q, frame_err_d;
  logic [2:0]          frame_ch_q, frame_ch_d;
  logic [15:0]         frame_num_q, frame_num_d;

  logic                addr_hit;
  logic [2:0]          addr_off;
  logic                timeout_hit;
  logic [CHANNELS-1:0] ch_onehot;

  // Address decode on the ADDR word. The channel offset only needs the low
  // three bits of the difference, which depend only on the low address bits.
  assign addr_hit = (in_data[15:8] >= BASE_ADDR) &&
                    ({1'b0, in_data[15:8]} < ({1'b0, BASE_ADDR} + 9'(CHANNELS)));
  assign addr_off = in_data[10:8] - BASE_ADDR[2:0];

  // The timeout fires in the TIMEOUT-th consecutive idle busy cycle; a word
  // arriving in that same cycle is consumed instead.
  assign timeout_hit = (state_q != ST_IDLE) && !in_valid &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT - 1));

  assign ch_onehot = CHANNELS'(1) << ch_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= ST_IDLE;
      sum_q        <= '0;
      remain_q     <= '0;
      matched_q    <= 1'b0;
      ch_q         <= '0;
      csum_ok_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      out_cmd_q    <= '0;
      out_commit_q <= '0;
      out_abort_q  <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= '0;
      frame_ch_q   <= '0;
      frame_num_q  <= '0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      remain_q     <= remain_d;
      matched_q    <= matched_d;
      ch_q         <= ch_d;
      csum_ok_q    <= csum_ok_d;
      tmo_cnt_q    <= tmo_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_cmd_q    <= out_cmd_d;
      out_commit_q <= out_commit_d;
      out_abort_q  <= out_abort_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      frame_ch_q   <= frame_ch_d;
      frame_num_q  <= frame_num_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (timeout_hit) begin
      state_d = ST_IDLE;
    end else if (in_valid) begin
      unique case (state_q)
        ST_IDLE: state_d = ST_SIZE;
        ST_SIZE: state_d = (in_data[15:8] == 8'd0) ? ST_CSUM : ST_DATA;
        ST_DATA: state_d = (remain_q == 8'd1) ? ST_CSUM : ST_DATA;
        ST_CSUM: state_d = ST_NUM;
        ST_NUM:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output logic.
  always_comb begin
    sum_d        = sum_q;
    remain_d     = remain_q;
    matched_d    = matched_q;
    ch_d         = ch_q;
    csum_ok_d    = csum_ok_q;
    tmo_cnt_d    = (state_q != ST_IDLE && !in_valid) ? tmo_cnt_q + CNT_W'(1) : '0;
    out_data_d   = out_data_q;
    out_valid_d  = '0;
    out_cmd_d    = out_cmd_q;
    out_commit_d = '0;
    out_abort_d  = '0;
    frame_done_d = 1'b0;
    frame_err_d  = ERR_OK;
    frame_ch_d   = '0;
    frame_num_d  = '0;

    if (timeout_hit) begin
      tmo_cnt_d    = '0;
      frame_done_d = 1'b1;
      frame_err_d  = ERR_TIMEOUT;
      frame_ch_d   = ch_q;
      if (matched_q) begin
        out_abort_d = ch_onehot;
      end
    end else if (in_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          sum_d     = in_data;
          matched_d = addr_hit;
          ch_d      = addr_hit ? addr_off : 3'd0;
        end
        ST_SIZE: begin
          sum_d     = sum_q + in_data;
          remain_d  = in_data[15:8];
          out_cmd_d = in_data[7:0];
        end
        ST_DATA: begin
          sum_d      = sum_q + in_data;
          remain_d   = remain_q - 8'd1;
          out_data_d = in_data;
          if (matched_q) begin
            out_valid_d = ch_onehot;
          end
        end
        ST_CSUM: begin
          csum_ok_d = (in_data == sum_q);
        end
        ST_NUM: begin
          frame_done_d = 1'b1;
          frame_num_d  = in_data;
          frame_ch_d   = ch_q;
          // An unknown address outranks a checksum error.
          if (!matched_q) begin
            frame_err_d = ERR_ADDR;
          end else if (csum_ok_q) begin
            out_commit_d = ch_onehot;
          end else begin
            out_abort_d = ch_onehot;
            frame_err_d = ERR_CSUM;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_cmd    = out_cmd_q;
  assign out_commit = out_commit_q;
  assign out_abort  = out_abort_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign frame_ch   = frame_ch_q;
  assign frame_num  = frame_num_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mil_spi_frame_router.sv
// Testbench for mil_spi_frame_router with CHANNELS=2, BASE_ADDR=AB and a short
// timeout. A frame-level model predicts, per cycle, the forwarded words, the
// frame-end record, out_cmd and busy; a compare process checks the DUT against
// it every cycle, and literal expectations after each scenario pin the model.

module tb_mil_spi_frame_router;

  localparam int         CH   = 2;
  localparam logic [7:0] BASE = 8'hAB;
  localparam int         TMO  = 16;

  logic          clk = 1'b0;
  logic          nRst;
  logic [15:0]   in_data;
  logic          in_valid;
  logic [15:0]   out_data;
  logic [CH-1:0] out_valid;
  logic [7:0]    out_cmd;
  logic [CH-1:0] out_commit;
  logic [CH-1:0] out_abort;
  logic          frame_done;
  logic [1:0]    frame_err;
  logic [2:0]    frame_ch;
  logic [15:0]   frame_num;
  logic          busy;

  mil_spi_frame_router #(
    .CHANNELS (CH),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TMO)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_cmd   (out_cmd),
    .out_commit(out_commit),
    .out_abort (out_abort),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .frame_ch  (frame_ch),
    .frame_num (frame_num),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    int          ch;
    logic [15:0] data;
  } data_exp_t;

  typedef struct {
    int          cyc;
    logic [1:0]  err;
    int          ch;
    logic [15:0] num;
    logic [1:0]  commit;
    logic [1:0]  abort;
  } done_exp_t;

  typedef struct {
    int         cyc;
    logic [7:0] cmd;
  } cmd_exp_t;

  typedef struct {
    int cyc;
    bit val;
  } busy_exp_t;

  typedef struct {
    logic [1:0]  err;
    logic [2:0]  ch;
    logic [15:0] num;
    logic [1:0]  commit;
    logic [1:0]  abort;
  } done_rec_t;

  data_exp_t dataQ[$];
  done_exp_t doneQ[$];
  cmd_exp_t  cmdQ[$];
  busy_exp_t busyQ[$];
  done_rec_t doneLog[$];

  bit          modelOn = 1'b0;
  logic [7:0]  expCmd  = 8'h00;
  bit          expBusy = 1'b0;
  int          fwdCount = 0;
  logic [15:0] lastWord = 16'h0;
  logic [15:0] fr[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle; entered and left at posedge+1.
  task automatic driveCycle(input bit v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) driveCycle(1'b0, 16'h0000);
  endtask

  // Sends the first nSend words of frame w (gapLen idle cycles before word
  // gapIdx) and records what the router must produce, frame by frame.
  task automatic applyStimulus(input logic [15:0] w[$], input int nSend,
                               input int gapIdx, input int gapLen);
    logic [7:0]  addr;
    bit          matched;
    int          ch;
    int          size;
    logic [15:0] sum;
    bit          full;
    bit          csumOk;
    logic [1:0]  err;
    logic [1:0]  oh;
    int          s;
    int          last;

    addr    = w[0][15:8];
    matched = (addr >= BASE) && (int'(addr) < int'(BASE) + CH);
    ch      = matched ? int'(addr) - int'(BASE) : 0;
    oh      = matched ? 2'(1 << ch) : 2'b00;
    size    = int'(w[1][15:8]);
    sum     = 16'h0;
    for (int j = 0; j < 2 + size && j < w.size(); j++) sum = sum + w[j];
    full    = (nSend >= size + 4) && (w.size() >= size + 4);
    csumOk  = full && (w[2 + size] == sum);
    err     = !matched ? 2'd3 : (csumOk ? 2'd0 : 2'd1);

    for (int i = 0; i < nSend; i++) begin
      if (i == gapIdx) idle(gapLen);
      s = cyc + 1;
      if (i == 0) busyQ.push_back('{s, 1'b1});
      if (i == 1) cmdQ.push_back('{s, w[1][7:0]});
      if (i >= 2 && i < 2 + size && matched) dataQ.push_back('{s, ch, w[i]});
      if (i == 3 + size) begin
        doneQ.push_back('{s, err, ch, w[i],
                          (err == 2'd0) ? oh : 2'b00,
                          (err == 2'd1) ? oh : 2'b00});
        busyQ.push_back('{s, 1'b0});
      end
      driveCycle(1'b1, w[i]);
    end

    if (!full) begin
      last = cyc;
      doneQ.push_back('{last + TMO, 2'd2, ch, 16'h0000, 2'b00, oh});
      busyQ.push_back('{last + TMO, 1'b0});
      idle(TMO + 3);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    data_exp_t d;
    done_exp_t e;
    if (nRst && modelOn) begin
      while (busyQ.size() > 0 && busyQ[0].cyc <= cyc) begin
        expBusy = busyQ[0].val;
        void'(busyQ.pop_front());
      end
      while (cmdQ.size() > 0 && cmdQ[0].cyc <= cyc) begin
        expCmd = cmdQ[0].cmd;
        void'(cmdQ.pop_front());
      end
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("out_cmd", 32'(out_cmd), 32'(expCmd));

      if (dataQ.size() > 0 && dataQ[0].cyc == cyc) begin
        d = dataQ.pop_front();
        checkOutput("out_valid", 32'(out_valid), 32'(1 << d.ch));
        checkOutput("out_data", 32'(out_data), 32'(d.data));
      end else begin
        checkOutput("out_valid_quiet", 32'(out_valid), 32'h0);
      end

      if (doneQ.size() > 0 && doneQ[0].cyc == cyc) begin
        e = doneQ.pop_front();
        checkOutput("frame_done", 32'(frame_done), 32'h1);
        checkOutput("frame_err", 32'(frame_err), 32'(e.err));
        checkOutput("frame_num", 32'(frame_num), 32'(e.num));
        checkOutput("out_commit", 32'(out_commit), 32'(e.commit));
        checkOutput("out_abort", 32'(out_abort), 32'(e.abort));
        if (e.err != 2'd3) checkOutput("frame_ch", 32'(frame_ch), 32'(e.ch));
      end else begin
        checkOutput("frame_done_quiet", 32'(frame_done), 32'h0);
        checkOutput("out_commit_quiet", 32'(out_commit), 32'h0);
        checkOutput("out_abort_quiet", 32'(out_abort), 32'h0);
      end

      if (out_valid != '0) begin
        fwdCount++;
        lastWord = out_data;
      end
      if (frame_done) doneLog.push_back('{frame_err, frame_ch, frame_num, out_commit, out_abort});
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_out_data"}, 32'(out_data), 32'h0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({tag, "_out_cmd"}, 32'(out_cmd), 32'h0);
    checkOutput({tag, "_out_commit"}, 32'(out_commit), 32'h0);
    checkOutput({tag, "_out_abort"}, 32'(out_abort), 32'h0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    checkOutput({tag, "_frame_ch"}, 32'(frame_ch), 32'h0);
    checkOutput({tag, "_frame_num"}, 32'(frame_num), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic checkLastDone(input string tag, input logic [1:0] err, input logic [2:0] ch,
                               input logic [15:0] num, input logic [1:0] commit,
                               input logic [1:0] abort, input int back);
    int idx;
    idx = doneLog.size() - 1 - back;
    if (idx < 0) begin
      checkOutput({tag, "_done_seen"}, 32'(doneLog.size()), 32'(back + 1));
    end else begin
      checkOutput({tag, "_err"}, 32'(doneLog[idx].err), 32'(err));
      if (err != 2'd3) checkOutput({tag, "_ch"}, 32'(doneLog[idx].ch), 32'(ch));
      checkOutput({tag, "_num"}, 32'(doneLog[idx].num), 32'(num));
      checkOutput({tag, "_commit"}, 32'(doneLog[idx].commit), 32'(commit));
      checkOutput({tag, "_abort"}, 32'(doneLog[idx].abort), 32'(abort));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    nRst     = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    nRst    = 1'b1;
    modelOn = 1'b1;
    idle(2);

    $display("[TB] good frame");
    fr = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45,
           16'hFFA3, 16'hFFA1, 16'h5BCF, 16'h0000};
    fwdCount = 0;
    applyStimulus(fr, 10, -1, 0);
    idle(2);
    checkOutput("good_fwd_count", 32'(fwdCount), 32'd6);
    checkOutput("good_last_word", 32'(lastWord), 32'hFFA1);
    checkOutput("good_cmd", 32'(out_cmd), 32'hA2);
    checkLastDone("good", 2'd0, 3'd0, 16'h0000, 2'b01, 2'b00, 0);

    $display("[TB] bad checksum");
    fr[8] = 16'h5BCE;
    fwdCount = 0;
    applyStimulus(fr, 10, -1, 0);
    idle(2);
    checkOutput("bad_fwd_count", 32'(fwdCount), 32'd6);
    checkLastDone("bad", 2'd1, 3'd0, 16'h0000, 2'b00, 2'b01, 0);

    $display("[TB] zero-size frame");
    fr = '{16'hAC00, 16'h00B2, 16'hACB2, 16'h0003};
    fwdCount = 0;
    applyStimulus(fr, 4, -1, 0);
    idle(2);
    checkOutput("zero_fwd_count", 32'(fwdCount), 32'd0);
    checkOutput("zero_cmd", 32'(out_cmd), 32'hB2);
    checkLastDone("zero", 2'd0, 3'd1, 16'h0003, 2'b10, 2'b00, 0);

    $display("[TB] unknown address then back-to-back good frame");
    fr = '{16'hAF00, 16'h01A2, 16'h1234, 16'hC0D6, 16'h0000};
    fwdCount = 0;
    applyStimulus(fr, 5, -1, 0);
    fr = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45,
           16'hFFA3, 16'hFFA1, 16'h5BCF, 16'h0000};
    applyStimulus(fr, 10, -1, 0);
    idle(2);
    checkOutput("unk_fwd_count", 32'(fwdCount), 32'd6);
    checkLastDone("unk", 2'd3, 3'd0, 16'h0000, 2'b00, 2'b00, 1);
    checkLastDone("after_unk", 2'd0, 3'd0, 16'h0000, 2'b01, 2'b00, 0);

    $display("[TB] timeout");
    fr = '{16'hAB00, 16'h06A2, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
           16'h0005, 16'h0006, 16'h0000, 16'h0000};
    applyStimulus(fr, 3, -1, 0);
    checkOutput("tmo_busy", 32'(busy), 32'h0);
    checkLastDone("tmo", 2'd2, 3'd0, 16'h0000, 2'b00, 2'b01, 0);
    fr = '{16'hAB00, 16'h06A2, 16'hFFA1, 16'h0001, 16'h0002, 16'hAB45,
           16'hFFA3, 16'hFFA1, 16'h5BCF, 16'h0000};
    applyStimulus(fr, 10, -1, 0);
    idle(2);
    checkLastDone("after_tmo", 2'd0, 3'd0, 16'h0000, 2'b01, 2'b00, 0);

    $display("[TB] longest gap that does not time out");
    fwdCount = 0;
    applyStimulus(fr, 10, 4, TMO - 1);
    idle(2);
    checkOutput("gap_fwd_count", 32'(fwdCount), 32'd6);
    checkLastDone("gap", 2'd0, 3'd0, 16'h0000, 2'b01, 2'b00, 0);

    $display("[TB] reset mid-frame");
    modelOn = 1'b0;
    driveCycle(1'b1, 16'hAB00);
    driveCycle(1'b1, 16'h06A2);
    driveCycle(1'b1, 16'hFFA1);
    nRst     = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    #1;
    checkAllZero("midreset");
    dataQ.delete();
    doneQ.delete();
    cmdQ.delete();
    busyQ.delete();
    expCmd  = 8'h00;
    expBusy = 1'b0;
    @(posedge clk);
    #1;
    nRst    = 1'b1;
    modelOn = 1'b1;
    idle(1);
    fwdCount = 0;
    applyStimulus(fr, 10, -1, 0);
    idle(2);
    checkOutput("rst_fwd_count", 32'(fwdCount), 32'd6);
    checkLastDone("after_rst", 2'd0, 3'd0, 16'h0000, 2'b01, 2'b00, 0);
    checkOutput("model_drained", 32'(dataQ.size() + doneQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
